axi_wr_mon: RTL and testbench

- Synthesizable multi-channel monitor for AXI3 write traffic from the scope, GPIO and DAC stream engines into the HP ports.
- Taps each channel's AW and W handshakes passively and never drives AXI signals.
- Per channel, queues outstanding AW bursts, reconstructs the per-beat address, and counts beats and valid samples.
- Flags protocol errors in sticky bits that software reads through the register bank.

---
 rtl/axi_wr_mon.sv | 184 ++++++++++++++++++
 tb/tb_axi_wr_mon.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_mon.sv
// Passive AXI3 write-channel monitor: per-channel AW queue, beat address reconstruction,
// beat/sample counters and sticky protocol errors. Optional WID check: AXI_WMON_ID_CHK_EN.
module axi_wr_mon #(
   parameter int NUM_CH  = 5,
   parameter int DW      = 64,
   parameter int AW      = 32,
   parameter int IDW     = 4,
   parameter int LENW    = 4,
   parameter int SMP_W   = 16,
   parameter int Q_DEPTH = 4,
   parameter int CNT_W   = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic [NUM_CH-1:0]          awvalid_i,
   input  logic [NUM_CH-1:0]          awready_i,
   input  logic [NUM_CH*AW-1:0]       awaddr_i,
   input  logic [NUM_CH*LENW-1:0]     awlen_i,
   input  logic [NUM_CH*IDW-1:0]      awid_i,
   input  logic [NUM_CH-1:0]          wvalid_i,
   input  logic [NUM_CH-1:0]          wready_i,
   input  logic [NUM_CH-1:0]          wlast_i,
   input  logic [NUM_CH*IDW-1:0]      wid_i,
   input  logic [NUM_CH*(DW/8)-1:0]   wstrb_i,
   output logic [NUM_CH*AW-1:0]       beat_adr_o,
   output logic [NUM_CH*CNT_W-1:0]    beat_cnt_o,
   output logic [NUM_CH*CNT_W-1:0]    smp_cnt_o,
   output logic [NUM_CH-1:0]          burst_done_o,
   output logic [NUM_CH*4-1:0]        err_o
);

   localparam int BPB    = DW / 8;
   localparam int ADR_SH = $clog2(BPB);
   localparam int SPB    = DW / SMP_W;
   localparam int STEP   = SMP_W / 8;
   localparam int PCW    = $clog2(SPB + 1);
   localparam int PW     = $clog2(Q_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ORPHAN} state_t;

   // One strobe bit per sample stands for the whole sample.
   function automatic logic [PCW-1:0] smp_pop(input logic [BPB-1:0] strb);
      logic [PCW-1:0] n;
      n = '0;
      for (int k = 0; k < SPB; k++) n = n + PCW'(strb[k*STEP]);
      return n;
   endfunction

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic            aw_acc, w_beat, wlast;
      logic [AW-1:0]   q_addr [Q_DEPTH];
      logic [LENW-1:0] q_len  [Q_DEPTH];
      logic [IDW-1:0]  q_id   [Q_DEPTH];
      logic [PW-1:0]   wr_ptr, rd_ptr;
      logic [PW:0]     q_cnt;
      logic            q_full, q_empty, push, pop;
      state_t          state, state_nxt;
      logic [LENW-1:0] idx, idx_nxt, cur_idx;
      logic            matched, orphan_set, len_set, id_set, ovf_set, done_set;
      logic [AW-1:0]   adr_cur;
      logic [CNT_W-1:0] beat_cnt, smp_cnt;
      logic [CNT_W:0]  smp_sum;
      logic [AW-1:0]   beat_adr;
      logic [3:0]      err;
      logic            done_q;

      assign aw_acc  = awvalid_i[c] & awready_i[c];
      assign w_beat  = wvalid_i[c] & wready_i[c];
      assign wlast   = wlast_i[c];
      assign q_full  = (q_cnt == (PW+1)'(Q_DEPTH));
      assign q_empty = (q_cnt == '0);
      assign push    = aw_acc & (~q_full | pop);
      assign ovf_set = aw_acc & q_full & ~pop;
      assign cur_idx = (state == ST_BURST) ? idx : '0;
      assign adr_cur = q_addr[rd_ptr] + (AW'(cur_idx) << ADR_SH);
      assign matched = w_beat & ((state == ST_BURST) | ((state == ST_IDLE) & ~q_empty));

`ifdef AXI_WMON_ID_CHK_EN
      assign id_set = matched & (wid_i[c*IDW +: IDW] != q_id[rd_ptr]);
`else
      logic unused_id;
      assign unused_id = ^{wid_i[c*IDW +: IDW], q_id[rd_ptr]};
      assign id_set    = 1'b0;
`endif

      // NOTE: every signal written here gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      always_comb begin
         state_nxt  = state;
         idx_nxt    = idx;
         pop        = 1'b0;
         len_set    = 1'b0;
         done_set   = 1'b0;
         orphan_set = 1'b0;
         if (matched) begin
            if (wlast || cur_idx == q_len[rd_ptr]) begin
               len_set   = ~wlast | (cur_idx != q_len[rd_ptr]);
               pop       = 1'b1;
               done_set  = 1'b1;
               idx_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               idx_nxt   = cur_idx + 1'b1;
               state_nxt = ST_BURST;
            end
         end else if (w_beat) begin
            case (state)
               ST_IDLE: begin
                  orphan_set = 1'b1;
                  state_nxt  = wlast ? ST_IDLE : ST_ORPHAN;
               end
               ST_ORPHAN: if (wlast) state_nxt = ST_IDLE;
               default:   state_nxt = ST_IDLE;
            endcase
         end
      end

      // NOTE: state is updated with non-blocking assignments so every register samples
      // values from before the edge, independent of process order.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state  <= ST_IDLE;
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
         end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   q_cnt <= q_cnt + 1'b1;
               2'b01:   q_cnt <= q_cnt - 1'b1;
               default: q_cnt <= q_cnt;
            endcase
         end
      end

      // NOTE: queue storage is not reset; emptiness is tracked by q_cnt alone, so stale
      // entries are never observed.
      always_ff @(posedge clk_i) begin
         if (push) begin
            q_addr[wr_ptr] <= awaddr_i[c*AW +: AW];
            q_len[wr_ptr]  <= awlen_i[c*LENW +: LENW];
            q_id[wr_ptr]   <= awid_i[c*IDW +: IDW];
         end
      end

      assign smp_sum = {1'b0, smp_cnt} + (CNT_W+1)'(smp_pop(wstrb_i[c*BPB +: BPB]));

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            beat_adr <= '0;
            beat_cnt <= '0;
            smp_cnt  <= '0;
            err      <= '0;
            done_q   <= 1'b0;
         end else begin
            done_q <= done_set;
            if (matched) beat_adr <= adr_cur;
            if (clr_i) begin
               beat_cnt <= '0;
               smp_cnt  <= '0;
               err      <= '0;
            end else begin
               if (w_beat) begin
                  if (!(&beat_cnt)) beat_cnt <= beat_cnt + 1'b1;
                  smp_cnt <= smp_sum[CNT_W] ? '1 : smp_sum[CNT_W-1:0];
               end
               err <= err | {orphan_set, ovf_set, len_set, id_set};
            end
         end
      end

      assign beat_adr_o[c*AW +: AW]       = beat_adr;
      assign beat_cnt_o[c*CNT_W +: CNT_W] = beat_cnt;
      assign smp_cnt_o[c*CNT_W +: CNT_W]  = smp_cnt;
      assign burst_done_o[c]              = done_q;
      assign err_o[c*4 +: 4]              = err;
   end

endmodule

// File: tb/tb_axi_wr_mon.sv
// Directed bench for axi_wr_mon; a second narrow-counter instance exercises saturation.
module tb_axi_wr_mon;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_i, clr_i;
   logic [4:0]   awvalid, awready, wvalid, wready, wlast;
   logic [159:0] awaddr;
   logic [19:0]  awlen, awid, wid;
   logic [39:0]  wstrb;
   logic [159:0] beat_adr_o, beat_cnt_o, smp_cnt_o;
   logic [4:0]   burst_done_o;
   logic [19:0]  err_o;

   logic         s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
   logic [31:0]  s_awaddr, s_beat_adr;
   logic [3:0]   s_awlen, s_awid, s_wid, s_err;
   logic [7:0]   s_wstrb;
   logic [1:0]   s_beat_cnt, s_smp_cnt;
   logic         s_done;

   int cmp_cnt = 0;
   int mis_cnt = 0;

`ifdef AXI_WMON_ID_CHK_EN
   localparam logic [3:0] ID_ERR_EXP = 4'b0001;
`else
   localparam logic [3:0] ID_ERR_EXP = 4'b0000;
`endif

   axi_wr_mon u_dut (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
      .awvalid_i(awvalid), .awready_i(awready), .awaddr_i(awaddr),
      .awlen_i(awlen), .awid_i(awid),
      .wvalid_i(wvalid), .wready_i(wready), .wlast_i(wlast),
      .wid_i(wid), .wstrb_i(wstrb),
      .beat_adr_o(beat_adr_o), .beat_cnt_o(beat_cnt_o), .smp_cnt_o(smp_cnt_o),
      .burst_done_o(burst_done_o), .err_o(err_o)
   );

   axi_wr_mon #(.NUM_CH(1), .CNT_W(2)) u_sat (
      .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
      .awvalid_i(s_awvalid), .awready_i(s_awready), .awaddr_i(s_awaddr),
      .awlen_i(s_awlen), .awid_i(s_awid),
      .wvalid_i(s_wvalid), .wready_i(s_wready), .wlast_i(s_wlast),
      .wid_i(s_wid), .wstrb_i(s_wstrb),
      .beat_adr_o(s_beat_adr), .beat_cnt_o(s_beat_cnt), .smp_cnt_o(s_smp_cnt),
      .burst_done_o(s_done), .err_o(s_err)
   );

   function automatic logic [31:0] adr(input int ch);  return beat_adr_o[ch*32 +: 32]; endfunction
   function automatic logic [31:0] bcnt(input int ch); return beat_cnt_o[ch*32 +: 32]; endfunction
   function automatic logic [31:0] scnt(input int ch); return smp_cnt_o[ch*32 +: 32];  endfunction
   function automatic logic [3:0]  err(input int ch);  return err_o[ch*4 +: 4];        endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_all();
      awvalid = '0; awready = '0; wvalid = '0; wready = '0; wlast = '0; clr_i = 1'b0;
      s_awvalid = 1'b0; s_awready = 1'b0; s_wvalid = 1'b0; s_wready = 1'b0; s_wlast = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle_all();
   endtask

   task automatic set_aw(input int ch, input logic [31:0] a, input logic [3:0] l,
                         input logic [3:0] id);
      awvalid[ch] = 1'b1; awready[ch] = 1'b1;
      awaddr[ch*32 +: 32] = a; awlen[ch*4 +: 4] = l; awid[ch*4 +: 4] = id;
   endtask

   task automatic set_w(input int ch, input logic [7:0] s, input logic last,
                        input logic [3:0] id);
      wvalid[ch] = 1'b1; wready[ch] = 1'b1; wlast[ch] = last;
      wstrb[ch*8 +: 8] = s; wid[ch*4 +: 4] = id;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      awaddr = '0; awlen = '0; awid = '0; wid = '0; wstrb = '0;
      s_awaddr = '0; s_awlen = '0; s_awid = '0; s_wid = '0; s_wstrb = '0;
      idle_all();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;

      for (int ch = 0; ch < 5; ch++) begin
         check("rst_adr", adr(ch), 0);
         check("rst_cnt", bcnt(ch), 0);
         check("rst_smp", scnt(ch), 0);
         check("rst_err", err(ch), 0);
      end
      check("rst_done", burst_done_o, 0);

      // Four-beat burst with full strobes.
      set_aw(0, 32'h1000_0000, 4'd3, 4'd0); tick();
      for (int i = 0; i < 4; i++) begin
         set_w(0, 8'hFF, i == 3, 4'd0); tick();
         check("b1_adr", adr(0), 32'h1000_0000 + 32'(i * 8));
         check("b1_done", burst_done_o[0], (i == 3));
      end
      tick();
      check("b1_done_end", burst_done_o[0], 0);
      check("b1_cnt", bcnt(0), 4);
      check("b1_smp", scnt(0), 16);
      check("b1_err", err(0), 0);

      // Partial strobes: 0x0F carries 2 samples, 0x03 carries 1.
      set_aw(0, 32'h2000_0000, 4'd1, 4'd0); tick();
      set_w(0, 8'h0F, 1'b0, 4'd0); tick();
      check("strb0f_smp", scnt(0), 18);
      set_w(0, 8'h03, 1'b1, 4'd0); tick();
      check("strb03_smp", scnt(0), 19);
      check("strb_cnt", bcnt(0), 6);
      check("strb_adr", adr(0), 32'h2000_0008);
      check("strb_done", burst_done_o[0], 1);

      // Queue overflow on channel 1.
      for (int i = 0; i < 5; i++) begin
         set_aw(1, 32'h3000_0000 + 32'(i * 256), 4'd0, 4'd0); tick();
         check("ovf_err", err(1), (i == 4) ? 4'b0100 : 4'b0000);
      end
      clr_i = 1'b1; tick();
      check("clr_err", err(1), 0);
      check("clr_cnt", bcnt(0), 0);
      check("clr_smp", scnt(0), 0);
      check("clr_adr_hold", adr(0), 32'h2000_0008);
      set_aw(1, 32'h3000_0400, 4'd0, 4'd0);
      set_w(1, 8'hFF, 1'b1, 4'd0); tick();
      check("full_pop_err", err(1), 0);
      check("full_pop_adr", adr(1), 32'h3000_0000);
      check("full_pop_done", burst_done_o[1], 1);
      for (int i = 1; i < 5; i++) begin
         set_w(1, 8'hFF, 1'b1, 4'd0); tick();
         check("drain_adr", adr(1), 32'h3000_0000 + 32'(i * 256));
      end
      check("drain_err", err(1), 0);
      check("drain_cnt", bcnt(1), 5);

      // Early WLAST, then a correctly matched follow-up burst.
      set_aw(2, 32'h4000_0000, 4'd3, 4'd0); tick();
      set_w(2, 8'hFF, 1'b0, 4'd0); tick();
      set_w(2, 8'hFF, 1'b1, 4'd0); tick();
      check("early_err", err(2), 4'b0010);
      check("early_done", burst_done_o[2], 1);
      check("early_adr", adr(2), 32'h4000_0008);
      set_aw(2, 32'h5000_0000, 4'd0, 4'd0); tick();
      set_w(2, 8'hFF, 1'b1, 4'd0); tick();
      check("next_adr", adr(2), 32'h5000_0000);
      check("next_err", err(2), 4'b0010);

      // Missing WLAST at the last beat, then orphan beats until WLAST.
      clr_i = 1'b1; tick();
      set_aw(2, 32'h6000_0000, 4'd0, 4'd0); tick();
      set_w(2, 8'hFF, 1'b0, 4'd0); tick();
      check("nolast_err", err(2), 4'b0010);
      check("nolast_done", burst_done_o[2], 1);
      check("nolast_adr", adr(2), 32'h6000_0000);
      set_w(2, 8'hFF, 1'b0, 4'd0); tick();
      check("orph_err", err(2), 4'b1010);
      check("orph_adr", adr(2), 32'h6000_0000);
      check("orph_done", burst_done_o[2], 0);
      set_w(2, 8'hFF, 1'b1, 4'd0); tick();
      check("orph_last_done", burst_done_o[2], 0);
      set_aw(2, 32'h7000_0000, 4'd0, 4'd0); tick();
      set_w(2, 8'hFF, 1'b1, 4'd0); tick();
      check("after_orph_adr", adr(2), 32'h7000_0000);
      check("after_orph_done", burst_done_o[2], 1);
      check("after_orph_cnt", bcnt(2), 4);

      // Beat before any AW on a fresh channel.
      set_w(3, 8'hFF, 1'b1, 4'd0); tick();
      check("pre_aw_err", err(3), 4'b1000);
      check("pre_aw_cnt", bcnt(3), 1);
      check("pre_aw_smp", scnt(3), 4);
      check("pre_aw_adr", adr(3), 0);

      // WID check: matching id, then mismatching id.
      set_aw(4, 32'hA000_0000, 4'd0, 4'd5); tick();
      set_w(4, 8'hFF, 1'b1, 4'd5); tick();
      check("id_ok_err", err(4), 0);
      set_aw(4, 32'hA000_0100, 4'd0, 4'd5); tick();
      set_w(4, 8'hFF, 1'b1, 4'd6); tick();
      check("id_bad_err", err(4), ID_ERR_EXP);
      check("id_bad_adr", adr(4), 32'hA000_0100);

      // Clear in the same cycle as a beat wins over the increment.
      set_aw(0, 32'h8000_0000, 4'd0, 4'd0); tick();
      set_w(0, 8'hFF, 1'b1, 4'd0); clr_i = 1'b1; tick();
      check("clr_beat_cnt", bcnt(0), 0);
      check("clr_beat_smp", scnt(0), 0);
      check("clr_beat_adr", adr(0), 32'h8000_0000);
      check("clr_beat_done", burst_done_o[0], 1);
      check("clr_beat_err3", err(3), 0);

      // Reset mid-burst; the next beat is an orphan.
      set_aw(0, 32'h9000_0000, 4'd3, 4'd0); tick();
      set_w(0, 8'hFF, 1'b0, 4'd0); tick();
      check("mid_adr", adr(0), 32'h9000_0000);
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      for (int ch = 0; ch < 5; ch++) begin
         check("mid_rst_adr", adr(ch), 0);
         check("mid_rst_cnt", bcnt(ch), 0);
         check("mid_rst_err", err(ch), 0);
      end
      set_w(0, 8'hFF, 1'b1, 4'd0); tick();
      check("post_rst_err", err(0), 4'b1000);
      check("post_rst_cnt", bcnt(0), 1);
      check("post_rst_adr", adr(0), 0);

      // Saturation on the 2-bit counter instance.
      s_awvalid = 1'b1; s_awready = 1'b1; s_awaddr = 32'h0; s_awlen = 4'd3; tick();
      for (int i = 0; i < 4; i++) begin
         s_wvalid = 1'b1; s_wready = 1'b1; s_wstrb = 8'hFF; s_wlast = (i == 3); tick();
         check("sat_cnt", s_beat_cnt, (i < 2) ? 2'(i + 1) : 2'd3);
         check("sat_smp", s_smp_cnt, 2'd3);
      end
      check("sat_err", s_err, 0);
      check("sat_done", s_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
